// File: rtl/nibble_serial_adder_ctrl.sv
// 16-bit adder sequenced through one shared 4-bit ripple-carry stage, LSB nibble first,
// with the held result scanned onto a 4-digit common-anode hex seven-segment display.
module nibble_serial_adder_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic        cout,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  state_e      state_q;
  logic [1:0]  idx_q;
  logic        carry_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] stage_q;
  logic [15:0] stage_d;
  logic [15:0] sum_q;
  logic        cout_q;

  logic [CNT_W-1:0] scan_cnt_q;
  logic [CNT_W-1:0] scan_cnt_d;
  logic [1:0]       digit_q;
  logic [1:0]       digit_d;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [4:0] nib_res;
  logic [3:0] disp_nib;

  // Active-low {g,f,e,d,c,b,a} hex glyphs for a common-anode digit.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // The single shared nibble adder; the carry between nibbles lives only in carry_q.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch can be inferred.
    stage_d = stage_q;
    a_nib   = a_q[{idx_q, 2'b00} +: 4];
    b_nib   = b_q[{idx_q, 2'b00} +: 4];
    nib_res = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    stage_d[{idx_q, 2'b00} +: 4] = nib_res[3:0];
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      carry_q <= 1'b0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      stage_q <= 16'h0000;
      sum_q   <= 16'h0000;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= 2'd0;
            state_q <= ADD;
          end
        end
        ADD: begin
          stage_q <= stage_d;
          carry_q <= nib_res[4];
          idx_q   <= idx_q + 2'd1;
          // Result and carry-out publish together so the display never sees a partial sum.
          if (idx_q == 2'd3) begin
            sum_q   <= stage_d;
            cout_q  <= nib_res[4];
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Display scan runs free of the FSM; the digit advances when the dwell counter wraps.
  always_comb begin
    scan_cnt_d = scan_cnt_q + CNT_W'(1);
    digit_d    = digit_q;
    if (scan_cnt_q == CNT_MAX) begin
      scan_cnt_d = '0;
      digit_d    = digit_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      digit_q    <= 2'd0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
    end
  end

  assign disp_nib = sum_q[{digit_q, 2'b00} +: 4];

  assign busy = (state_q == ADD);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign an   = ~(4'b0001 << digit_q);
  assign seg  = hex7(disp_nib);

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl with a short scan period for the display checks.
module tb_nibble_serial_adder_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic [6:0]  seg;
  logic [3:0]  an;

  int tests_run;
  int tests_failed;

  nibble_serial_adder_ctrl #(.SCAN_DIV(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .seg  (seg),
    .an   (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    tests_run++;
    if ({busy, done, cout} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctrl busy/done/cout=%b expected 000", {busy, done, cout});
    end
    tests_run++;
    if (sum !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_sum got %h expected 0000", sum);
    end
    tests_run++;
    if (an !== 4'b1110 || seg !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL reset_disp an=%b seg=%b expected 1110 1000000", an, seg);
    end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (busy !== 1'b1 || done !== 1'b0 || sum !== 16'h0000) begin
        tests_failed++;
        $display("FAIL basic_add_cycle%0d busy=%b done=%b sum=%h expected 1 0 0000", k, busy, done, sum);
      end
      tick();
    end
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done busy=%b done=%b expected 0 1", busy, done);
    end
    tests_run++;
    if (sum !== 16'h5555 || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_result sum=%h cout=%b expected 5555 0", sum, cout);
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_width busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_arith();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic        vc [4];
    logic [15:0] es [4];
    logic        ec [4];
    va[0] = 16'hFFFF; vb[0] = 16'h0001; vc[0] = 1'b0; es[0] = 16'h0000; ec[0] = 1'b1;
    va[1] = 16'h0000; vb[1] = 16'h0000; vc[1] = 1'b1; es[1] = 16'h0001; ec[1] = 1'b0;
    va[2] = 16'h8000; vb[2] = 16'h8000; vc[2] = 1'b1; es[2] = 16'h0001; ec[2] = 1'b1;
    va[3] = 16'h0FFF; vb[3] = 16'h0000; vc[3] = 1'b1; es[3] = 16'h1000; ec[3] = 1'b0;
    for (int v = 0; v < 4; v++) begin
      int waited;
      a = va[v]; b = vb[v]; cin = vc[v]; start = 1'b1;
      tick();
      start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = ~vc[v];
      waited = 0;
      while (done !== 1'b1 && waited < 10) begin
        tick();
        waited++;
      end
      tests_run++;
      if (waited != 4) begin
        tests_failed++;
        $display("FAIL arith%0d_latency cycles=%0d expected 4", v, waited);
      end
      tests_run++;
      if (sum !== es[v] || cout !== ec[v]) begin
        tests_failed++;
        $display("FAIL arith%0d_result sum=%h cout=%b expected %h %b", v, sum, cout, es[v], ec[v]);
      end
      tick();
    end
  endtask

  task automatic test_ignore_start();
    int          dones;
    logic [15:0] seen_sum;
    dones = 0; seen_sum = 16'hxxxx;
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 16'h7777; b = 16'h1111; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done === 1'b1) begin
        dones++;
        seen_sum = sum;
      end
      tick();
    end
    tests_run++;
    if (dones != 1) begin
      tests_failed++;
      $display("FAIL ignore_start_pulses got %0d expected 1", dones);
    end
    tests_run++;
    if (seen_sum !== 16'h1010) begin
      tests_failed++;
      $display("FAIL ignore_start_sum got %h expected 1010", seen_sum);
    end
  endtask

  task automatic test_back_to_back();
    int t_first;
    int t_second;
    int dones;
    t_first = -1; t_second = -1; dones = 0;
    a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 11) start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        if (t_first < 0) t_first = k;
        else if (t_second < 0) t_second = k;
      end
    end
    tests_run++;
    if (dones != 2) begin
      tests_failed++;
      $display("FAIL b2b_pulses got %0d expected 2", dones);
    end
    tests_run++;
    if (t_second - t_first != 6) begin
      tests_failed++;
      $display("FAIL b2b_spacing got %0d expected 6", t_second - t_first);
    end
    tests_run++;
    if (sum !== 16'h0003) begin
      tests_failed++;
      $display("FAIL b2b_sum got %h expected 0003", sum);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    int waited;
    dones = 0;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, cout} !== 3'b000 || sum !== 16'h0000) begin
      tests_failed++;
      $display("FAIL abort_outputs busy/done/cout=%b sum=%h expected 000 0000", {busy, done, cout}, sum);
    end
    tests_run++;
    if (an !== 4'b1110 || seg !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL abort_disp an=%b seg=%b expected 1110 1000000", an, seg);
    end
    #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    tests_run++;
    if (dones != 0) begin
      tests_failed++;
      $display("FAIL abort_no_done active_cycles=%0d expected 0", dones);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    waited = 0;
    while (done !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    tests_run++;
    if (done !== 1'b1 || sum !== 16'h3333 || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_restart done=%b sum=%h cout=%b expected 1 3333 0", done, sum, cout);
    end
    tick();
  endtask

  task automatic test_display();
    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];
    logic [3:0] prev_an;
    int         waited;
    exp_an[0] = 4'b1110; exp_seg[0] = 7'b0001110;
    exp_an[1] = 4'b1101; exp_seg[1] = 7'b1000000;
    exp_an[2] = 4'b1011; exp_seg[2] = 7'b0001000;
    exp_an[3] = 4'b0111; exp_seg[3] = 7'b0010010;
    a = 16'h5A0F; b = 16'h0000; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    // Align to the first cycle of digit 0.
    prev_an = an;
    tick();
    waited = 0;
    while (!(an === 4'b1110 && prev_an === 4'b0111) && waited < 24) begin
      prev_an = an;
      tick();
      waited++;
    end
    tests_run++;
    if (waited >= 24) begin
      tests_failed++;
      $display("FAIL disp_align an=%b expected transition 0111->1110", an);
    end
    for (int k = 0; k < 16; k++) begin
      tests_run++;
      if (an !== exp_an[k/4] || seg !== exp_seg[k/4]) begin
        tests_failed++;
        $display("FAIL disp_cycle%0d an=%b seg=%b expected %b %b", k, an, seg, exp_an[k/4], exp_seg[k/4]);
      end
      tick();
    end
    tests_run++;
    if (an !== 4'b1110 || seg !== 7'b0001110) begin
      tests_failed++;
      $display("FAIL disp_wrap an=%b seg=%b expected 1110 0001110", an, seg);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_arith();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_display();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
